// File: rtl/sensor_reg_sched_pkg.sv
// Shared types and constants for the sensor register write scheduler.
// Optional group-hold burst: SRS_GROUP_HOLD_EN.
package sensor_reg_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_NEXT,
        ST_DONE
    } srs_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } srs_wr_t;

    localparam logic [15:0] SRS_EXPO_H_ADDR = 16'h3501;
    localparam logic [15:0] SRS_EXPO_L_ADDR = 16'h3502;
    localparam logic [15:0] SRS_GAIN_H_ADDR = 16'h350A;
    localparam logic [15:0] SRS_GAIN_L_ADDR = 16'h350B;
    localparam logic [15:0] SRS_HOLD_ADDR   = 16'h3212;

    localparam int SRS_ACK_TIMEOUT = 65535;

    localparam logic [7:0] SRS_HOLD_START  = 8'h00;
    localparam logic [7:0] SRS_HOLD_END    = 8'h10;
    localparam logic [7:0] SRS_HOLD_LAUNCH = 8'hA0;

    // First step that releases group hold; a timeout skips ahead to it.
    localparam logic [2:0] SRS_HOLD_END_STEP = 3'd5;

endpackage

// File: rtl/srs_seq_rom.sv
// AE burst sequence table: step index + latched exposure/gain -> write.
// SRS_GROUP_HOLD_EN wraps the burst in group-hold writes.
module srs_seq_rom
    import sensor_reg_sched_pkg::*;
#(
    parameter logic [15:0] EXPO_H_ADDR = SRS_EXPO_H_ADDR,
    parameter logic [15:0] EXPO_L_ADDR = SRS_EXPO_L_ADDR,
    parameter logic [15:0] GAIN_H_ADDR = SRS_GAIN_H_ADDR,
`ifdef SRS_GROUP_HOLD_EN
    parameter logic [15:0] HOLD_ADDR   = SRS_HOLD_ADDR,
`endif
    parameter logic [15:0] GAIN_L_ADDR = SRS_GAIN_L_ADDR
) (
    input  logic [2:0] step_i,
    input  logic [9:0] expo_i,
    input  logic [9:0] gain_i,
    output srs_wr_t    wr_o,
    output logic       last_o
);

    // Table lookup; out-of-range steps read as a terminating empty entry.
    always_comb begin
        wr_o   = '0;
        last_o = 1'b0;
`ifdef SRS_GROUP_HOLD_EN
        unique case (step_i)
            3'd0: wr_o = {HOLD_ADDR, SRS_HOLD_START};
            3'd1: wr_o = {EXPO_H_ADDR, 6'b0, expo_i[9:8]};
            3'd2: wr_o = {EXPO_L_ADDR, expo_i[7:0]};
            3'd3: wr_o = {GAIN_H_ADDR, 6'b0, gain_i[9:8]};
            3'd4: wr_o = {GAIN_L_ADDR, gain_i[7:0]};
            3'd5: wr_o = {HOLD_ADDR, SRS_HOLD_END};
            3'd6: begin
                wr_o   = {HOLD_ADDR, SRS_HOLD_LAUNCH};
                last_o = 1'b1;
            end
            default: last_o = 1'b1;
        endcase
`else
        unique case (step_i)
            3'd0: wr_o = {EXPO_H_ADDR, 6'b0, expo_i[9:8]};
            3'd1: wr_o = {EXPO_L_ADDR, expo_i[7:0]};
            3'd2: wr_o = {GAIN_H_ADDR, 6'b0, gain_i[9:8]};
            3'd3: begin
                wr_o   = {GAIN_L_ADDR, gain_i[7:0]};
                last_o = 1'b1;
            end
            default: last_o = 1'b1;
        endcase
`endif
    end

endmodule

// File: rtl/sensor_reg_sched.sv
// Arbitrates AE bursts and host writes onto one SCCB write port.
// Optional group-hold burst: SRS_GROUP_HOLD_EN.
module sensor_reg_sched
    import sensor_reg_sched_pkg::*;
#(
    parameter logic [15:0] EXPO_H_ADDR = SRS_EXPO_H_ADDR,
    parameter logic [15:0] EXPO_L_ADDR = SRS_EXPO_L_ADDR,
    parameter logic [15:0] GAIN_H_ADDR = SRS_GAIN_H_ADDR,
    parameter logic [15:0] GAIN_L_ADDR = SRS_GAIN_L_ADDR,
`ifdef SRS_GROUP_HOLD_EN
    parameter logic [15:0] HOLD_ADDR   = SRS_HOLD_ADDR,
`endif
    parameter int          ACK_TIMEOUT = SRS_ACK_TIMEOUT
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        cmos_change_start,
    output logic        cmos_change_done,
    input  logic [9:0]  cmos_exposure,
    input  logic [9:0]  cmos_gain,
    input  logic        cfg_req,
    input  logic [15:0] cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic        cfg_ack,
    output logic        sccb_req,
    output logic [15:0] sccb_addr,
    output logic [7:0]  sccb_data,
    input  logic        sccb_ack,
    output logic        err_timeout
);

    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    srs_state_e  state_q, state_d;
    logic        armed_q, armed_d;
    logic        prio_cfg_q, prio_cfg_d;
    logic        is_ae_q, is_ae_d;
    logic [2:0]  step_q, step_d;
    logic [9:0]  expo_q, expo_d;
    logic [9:0]  gain_q, gain_d;
    srs_wr_t     cfg_q, cfg_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        done_q, done_d;
    logic        cfg_ack_q, cfg_ack_d;
    logic        req_q, req_d;
    srs_wr_t     wr_q, wr_d;
    logic        err_q, err_d;

    srs_wr_t     rom_wr;
    logic        rom_last;
    logic        ae_pend;
    logic        grant_ae;

    srs_seq_rom #(
        .EXPO_H_ADDR (EXPO_H_ADDR),
        .EXPO_L_ADDR (EXPO_L_ADDR),
        .GAIN_H_ADDR (GAIN_H_ADDR),
`ifdef SRS_GROUP_HOLD_EN
        .HOLD_ADDR   (HOLD_ADDR),
`endif
        .GAIN_L_ADDR (GAIN_L_ADDR)
    ) u_rom (
        .step_i (step_q),
        .expo_i (expo_q),
        .gain_i (gain_q),
        .wr_o   (rom_wr),
        .last_o (rom_last)
    );

    assign ae_pend  = cmos_change_start & armed_q;
    // On a collision the toggle picks whoever lost the previous one.
    assign grant_ae = ae_pend & (~cfg_req | ~prio_cfg_q);

    // Next-state and output-register logic of the scheduler FSM.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | ~cmos_change_start;
        prio_cfg_d = prio_cfg_q;
        is_ae_d    = is_ae_q;
        step_d     = step_q;
        expo_d     = expo_q;
        gain_d     = gain_q;
        cfg_d      = cfg_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        done_d     = done_q;
        cfg_ack_d  = 1'b0;
        req_d      = req_q;
        wr_d       = wr_q;
        err_d      = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ae_pend | cfg_req) begin
                    state_d = ST_ARB;
                    is_ae_d = grant_ae;
                    step_d  = '0;
                    if (ae_pend & cfg_req) prio_cfg_d = grant_ae;
                    if (grant_ae) begin
                        expo_d  = cmos_exposure;
                        gain_d  = cmos_gain;
                        armed_d = 1'b0;
                        done_d  = 1'b0;
                    end else begin
                        cfg_d = {cfg_addr, cfg_data};
                    end
                end
            end
            ST_ARB: begin
                state_d = ST_ISSUE;
                req_d   = 1'b1;
                cnt_d   = '0;
                wr_d    = is_ae_q ? rom_wr : cfg_q;
                last_d  = is_ae_q ? rom_last : 1'b1;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (sccb_ack) begin
                    state_d = ST_NEXT;
                    req_d   = 1'b0;
                    step_d  = 3'(step_q + 3'd1);
                end else if (cnt_q == TO_LAST) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
`ifdef SRS_GROUP_HOLD_EN
                    // Never leave the sensor in hold: jump to the release writes.
                    state_d = ST_NEXT;
                    step_d  = (step_q < SRS_HOLD_END_STEP) ?
                              SRS_HOLD_END_STEP : 3'(step_q + 3'd1);
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_NEXT: begin
                if (last_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    wr_d    = rom_wr;
                    last_d  = rom_last;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (is_ae_q) done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_DONE && state_q != ST_DONE) cfg_ack_d = ~is_ae_q;
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b1;
            prio_cfg_q <= 1'b0;
            is_ae_q    <= 1'b0;
            step_q     <= '0;
            expo_q     <= '0;
            gain_q     <= '0;
            cfg_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b1;
            cfg_ack_q  <= 1'b0;
            req_q      <= 1'b0;
            wr_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            prio_cfg_q <= prio_cfg_d;
            is_ae_q    <= is_ae_d;
            step_q     <= step_d;
            expo_q     <= expo_d;
            gain_q     <= gain_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            done_q     <= done_d;
            cfg_ack_q  <= cfg_ack_d;
            req_q      <= req_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
        end
    end

    assign cmos_change_done = done_q;
    assign cfg_ack          = cfg_ack_q;
    assign sccb_req         = req_q;
    assign sccb_addr        = wr_q.addr;
    assign sccb_data        = wr_q.data;
    assign err_timeout      = err_q;

endmodule

// File: tb/tb_sensor_reg_sched.sv
// Directed bench for sensor_reg_sched with a small SCCB responder.
// Expected burst contents follow SRS_GROUP_HOLD_EN when defined.
module tb_sensor_reg_sched;

    localparam int TO = 16;
`ifdef SRS_GROUP_HOLD_EN
    localparam int NB = 7;
    localparam int DROP = 3;
`else
    localparam int NB = 4;
    localparam int DROP = 2;
`endif

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic [9:0]  expo = '0;
    logic [9:0]  gain = '0;
    logic        cfg_req = 1'b0;
    logic [15:0] cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        cfg_ack;
    logic        req;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        sccb_ack = 1'b0;
    logic        err;

    always #5 pclk = ~pclk;

    sensor_reg_sched #(.ACK_TIMEOUT(TO)) dut (
        .pclk              (pclk),
        .rst_n             (rst_n),
        .cmos_change_start (start),
        .cmos_change_done  (done),
        .cmos_exposure     (expo),
        .cmos_gain         (gain),
        .cfg_req           (cfg_req),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .cfg_ack           (cfg_ack),
        .sccb_req          (req),
        .sccb_addr         (addr),
        .sccb_data         (data),
        .sccb_ack          (sccb_ack),
        .err_timeout       (err)
    );

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic [23:0] wlog[$];
    logic [23:0] exq[$];
    int          glog[$];
    int          hlog[$];
    int          drop_idx = 0;
    int          ack_pulses = 0;
    int          hi_n = 0;
    int          lo_n = 0;
    logic        prev_req = 1'b0;

    // SCCB responder and write logger; acks each write on its 2nd cycle.
    always @(negedge pclk) begin
        if (!rst_n) begin
            sccb_ack = 1'b0;
            prev_req = 1'b0;
        end else begin
            sccb_ack = 1'b0;
            if (req) begin
                if (!prev_req) begin
                    wlog.push_back({addr, data});
                    glog.push_back(lo_n);
                    hi_n = 0;
                end
                hi_n++;
                if (hi_n == 2 && drop_idx != wlog.size()) sccb_ack = 1'b1;
                lo_n = 0;
            end else begin
                if (prev_req) hlog.push_back(hi_n);
                lo_n++;
            end
            prev_req = req;
            if (cfg_ack) begin
                ack_pulses++;
                cfg_req = 1'b0;
            end
        end
    end

    function automatic void exp_ae(input logic [9:0] e, input logic [9:0] g);
`ifdef SRS_GROUP_HOLD_EN
        exq.push_back({16'h3212, 8'h00});
`endif
        exq.push_back({16'h3501, 6'b0, e[9:8]});
        exq.push_back({16'h3502, e[7:0]});
        exq.push_back({16'h350A, 6'b0, g[9:8]});
        exq.push_back({16'h350B, g[7:0]});
`ifdef SRS_GROUP_HOLD_EN
        exq.push_back({16'h3212, 8'h10});
        exq.push_back({16'h3212, 8'hA0});
`endif
    endfunction

    task automatic clr();
        wlog.delete();
        glog.delete();
        hlog.delete();
        exq.delete();
        ack_pulses = 0;
    endtask

    task automatic settle();
        repeat (80) @(negedge pclk);
    endtask

    task automatic cmp_log(input string tag, input int g_lo, input int g_hi);
        chk({tag, "_cnt"}, wlog.size(), exq.size());
        for (int i = 0; i < exq.size() && i < wlog.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), wlog[i], exq[i]);
        for (int i = g_lo; i <= g_hi && i < glog.size(); i++)
            chk($sformatf("%s_gap%0d", tag, i), glog[i], 1);
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        chk("rst_done", done, 1);
        chk("rst_ack", cfg_ack, 0);
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge pclk);

        // basic burst with latency
        clr();
        exp_ae(10'h2A5, 10'h13F);
        expo = 10'h2A5;
        gain = 10'h13F;
        start = 1'b1;
        @(negedge pclk);
        chk("done_fall", done, 0);
        chk("lat1_req", req, 0);
        @(negedge pclk);
        chk("lat2_req", req, 1);
        settle();
        chk("done_rise", done, 1);
        cmp_log("b1", 1, NB - 1);

        // held start must not retrigger
        clr();
        settle();
        chk("held_start", wlog.size(), 0);
        start = 1'b0;
        @(negedge pclk);
        clr();
        exp_ae(10'h3FF, 10'h000);
        expo = 10'h3FF;
        gain = 10'h000;
        start = 1'b1;
        settle();
        cmp_log("b2", 1, NB - 1);

        // collision: AE wins first
        start = 1'b0;
        @(negedge pclk);
        clr();
        exp_ae(10'h155, 10'h2AA);
        exq.push_back({16'h1234, 8'h5A});
        expo = 10'h155;
        gain = 10'h2AA;
        cfg_addr = 16'h1234;
        cfg_data = 8'h5A;
        start = 1'b1;
        cfg_req = 1'b1;
        settle();
        cmp_log("col1", 1, NB - 1);
        chk("col1_ack", ack_pulses, 1);

        // collision again: cfg wins
        start = 1'b0;
        @(negedge pclk);
        clr();
        exq.push_back({16'h4321, 8'hC3});
        exp_ae(10'h0AA, 10'h301);
        expo = 10'h0AA;
        gain = 10'h301;
        cfg_addr = 16'h4321;
        cfg_data = 8'hC3;
        start = 1'b1;
        cfg_req = 1'b1;
        settle();
        cmp_log("col2", 2, NB);
        chk("col2_ack", ack_pulses, 1);
        chk("col2_done", done, 1);

        // ack withheld: timeout and abort
        start = 1'b0;
        @(negedge pclk);
        clr();
        drop_idx = DROP;
`ifdef SRS_GROUP_HOLD_EN
        exq.push_back({16'h3212, 8'h00});
`endif
        exq.push_back({16'h3501, 8'h02});
        exq.push_back({16'h3502, 8'hA5});
`ifdef SRS_GROUP_HOLD_EN
        exq.push_back({16'h3212, 8'h10});
        exq.push_back({16'h3212, 8'hA0});
`endif
        expo = 10'h2A5;
        gain = 10'h13F;
        start = 1'b1;
        settle();
        cmp_log("to", 1, exq.size() - 1);
        chk("to_err", err, 1);
        chk("to_done", done, 1);
        chk("to_hi", hlog.size() >= DROP ? hlog[DROP-1] : 0, TO + 1);

        // reset while waiting for ack
        start = 1'b0;
        drop_idx = 1;
        @(negedge pclk);
        clr();
        start = 1'b1;
        repeat (5) @(negedge pclk);
        chk("mid_req", req, 1);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("mrst_req", req, 0);
        chk("mrst_done", done, 1);
        chk("mrst_err", err, 0);
        @(negedge pclk);
        rst_n = 1'b1;
        drop_idx = 0;
        @(negedge pclk);
        clr();
        exp_ae(10'h1C7, 10'h0E2);
        expo = 10'h1C7;
        gain = 10'h0E2;
        start = 1'b1;
        settle();
        cmp_log("post", 1, NB - 1);
        chk("post_err", err, 0);
        chk("post_done", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
